// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: sequences an operand load, compute and result drain
// for a square systolic PE array. It does not carry the operand or result
// data; it only produces the handshakes, beat indices and PE enable.
// Optional feature: define SYSTOLIC_PERF_CNT_EN to add the per-operation
// cycle counter behind perf_cycles. Otherwise perf_cycles is tied to 0.
// CFG_W must equal 2*DIM_W because config_data carries {rows, cols}.
module systolic_array_ctrl #(
   parameter int ARRAY_DIM = 4,
   parameter int DIM_W     = 16,
   parameter int CFG_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             config_valid,
   input  logic [CFG_W-1:0] config_data,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             pe_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIM_W-1:0] beat_idx,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       error_code,
   output logic [31:0]      perf_cycles
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_EXECUTE, S_STORE, S_DONE, S_ERROR
   } state_t;

   // Execute counter is wide enough for rows+cols+ARRAY_DIM.
   localparam int CNT_W = DIM_W + 2;
   localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(ARRAY_DIM);
   localparam logic [DIM_W-1:0] ONE     = DIM_W'(1);

   state_t           state_q, state_d;
   logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d;
   logic [DIM_W-1:0] beat_q, beat_d;
   logic             cfg_q, cfg_d;
   logic [1:0]       code_q, code_d;
   logic [CNT_W-1:0] exec_q, exec_d, exec_len;
   logic             dims_ok;

   assign dims_ok  = (rows_q != '0) && (cols_q != '0) &&
                     (rows_q <= DIM_MAX) && (cols_q <= DIM_MAX);
   // Counter runs 1..exec_len, giving rows+cols+ARRAY_DIM-2 compute cycles.
   assign exec_len = CNT_W'(rows_q) + CNT_W'(cols_q) + CNT_W'(ARRAY_DIM - 2);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rows_q  <= '0;
         cols_q  <= '0;
         beat_q  <= '0;
         cfg_q   <= 1'b0;
         code_q  <= 2'd0;
         exec_q  <= '0;
      end else begin
         state_q <= state_d;
         rows_q  <= rows_d;
         cols_q  <= cols_d;
         beat_q  <= beat_d;
         cfg_q   <= cfg_d;
         code_q  <= code_d;
         exec_q  <= exec_d;
      end
   end

   // Next-state logic; abort is tested first so it outranks any handshake.
   always_comb begin
      state_d = state_q;
      rows_d  = rows_q;
      cols_d  = cols_q;
      beat_d  = beat_q;
      cfg_d   = cfg_q;
      code_d  = code_q;
      exec_d  = exec_q;
      case (state_q)
         S_IDLE: begin
            beat_d = '0;
            if (config_valid) begin
               // A config strobe wins over a simultaneous start.
               rows_d = config_data[CFG_W-1:DIM_W];
               cols_d = config_data[DIM_W-1:0];
               cfg_d  = 1'b1;
            end else if (start) begin
               if (!cfg_q) begin
                  state_d = S_ERROR;
                  code_d  = 2'd2;
               end else if (!dims_ok) begin
                  state_d = S_ERROR;
                  code_d  = 2'd1;
               end else begin
                  state_d = S_LOAD_A;
                  code_d  = 2'd0;
               end
            end
         end
         S_LOAD_A: begin
            if (abort) begin
               state_d = S_ERROR;
               code_d  = 2'd3;
               beat_d  = '0;
            end else if (in_valid) begin
               if (beat_q + ONE == rows_q) begin
                  state_d = S_LOAD_B;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + ONE;
               end
            end
         end
         S_LOAD_B: begin
            if (abort) begin
               state_d = S_ERROR;
               code_d  = 2'd3;
               beat_d  = '0;
            end else if (in_valid) begin
               if (beat_q + ONE == cols_q) begin
                  state_d = S_EXECUTE;
                  beat_d  = '0;
                  exec_d  = CNT_W'(1);
               end else begin
                  beat_d = beat_q + ONE;
               end
            end
         end
         S_EXECUTE: begin
            if (abort) begin
               state_d = S_ERROR;
               code_d  = 2'd3;
            end else if (exec_q == exec_len) begin
               state_d = S_STORE;
               beat_d  = '0;
            end else begin
               exec_d = exec_q + CNT_W'(1);
            end
         end
         S_STORE: begin
            if (abort) begin
               state_d = S_ERROR;
               code_d  = 2'd3;
               beat_d  = '0;
            end else if (out_ready) begin
               if (beat_q + ONE == rows_q) begin
                  state_d = S_DONE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + ONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready   = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
   assign pe_en      = (state_q == S_EXECUTE);
   assign out_valid  = (state_q == S_STORE);
   assign busy       = in_ready || pe_en || out_valid;
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);
   assign beat_idx   = beat_q;
   assign error_code = code_q;

`ifdef SYSTOLIC_PERF_CNT_EN
   logic [31:0] pcnt_q, perf_q;
   logic        accept;

   assign accept = (state_q == S_IDLE) && (state_d == S_LOAD_A);

   // Count from the accepting cycle (=1) through DONE; publish only on done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q <= '0;
         perf_q <= '0;
      end else begin
         if (accept)
            pcnt_q <= 32'd1;
         else if (busy || done)
            pcnt_q <= pcnt_q + 32'd1;
         if (done)
            perf_q <= pcnt_q + 32'd1;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl at ARRAY_DIM=4: table of whole operations
// plus hand sequences for output stall, abort, config/start collision and
// reset in mid-operation. Result beats are checked against a scoreboard.
module tb_systolic_array_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        config_valid = 1'b0;
   logic [31:0] config_data = '0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        pe_en;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] beat_idx;
   logic        busy, done, error;
   logic [1:0]  error_code;
   logic [31:0] perf_cycles;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   systolic_array_ctrl #(.ARRAY_DIM(4), .DIM_W(16), .CFG_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .config_valid(config_valid),
      .config_data(config_data), .start(start), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .pe_en(pe_en),
      .out_valid(out_valid), .out_ready(out_ready), .beat_idx(beat_idx),
      .busy(busy), .done(done), .error(error), .error_code(error_code),
      .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] cfg;
      bit          err;
      int          code;
      int          nload;
      int          npe;
      int          nout;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_perf(input string nm, input int exp_on);
`ifdef SYSTOLIC_PERF_CNT_EN
      chk(nm, int'(perf_cycles), exp_on);
`else
      chk(nm, int'(perf_cycles), 0);
`endif
   endtask

   // Run one operation with in_valid/out_ready held high and tally outputs.
   task automatic run_op(input logic [31:0] cfg, input bit do_cfg, input bit exp_err,
                         input int exp_code, input int exp_load, input int exp_pe,
                         input int exp_out);
      int rows = int'(cfg[31:16]);
      int nload = 0, npe = 0, nout = 0, nidx0 = 0, cyc = 0, k = 0;
      bit fin = 0, saw_done = 0, saw_err = 0, busy_seen = 0;
      int perf_before;
      in_valid = 1'b1;
      out_ready = 1'b1;
      if (do_cfg) begin
         config_valid = 1'b1;
         config_data  = cfg;
         @(negedge clk);
         config_valid = 1'b0;
      end
      perf_before = int'(perf_cycles);
      start = 1'b1;
      if (!exp_err) for (int i = 0; i < rows; i++) exp_q.push_back(i);
      @(negedge clk);
      start = 1'b0;
      while (!fin && k < 300) begin
         k++;
         if (in_ready) begin
            nload++;
            if (beat_idx == 16'd0) nidx0++;
         end
         if (pe_en) npe++;
         if (busy) busy_seen = 1;
         if (out_valid && out_ready) begin
            nout++;
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sb_beat_idx", int'(beat_idx), exp_q.pop_front());
         end
         if (done) begin saw_done = 1; fin = 1; cyc = k + 1; end
         if (error) begin saw_err = 1; fin = 1; end
         if (!fin) @(negedge clk);
      end
      chk("op_timeout", int'(fin), 1);
      chk("op_done", int'(saw_done), int'(!exp_err));
      chk("op_error", int'(saw_err), int'(exp_err));
      chk("op_loads", nload, exp_load);
      chk("op_load_restarts", nidx0, exp_err ? 0 : 2);
      chk("op_pe_cycles", npe, exp_pe);
      chk("op_out_beats", nout, exp_out);
      chk("op_busy_seen", int'(busy_seen), int'(!exp_err));
      if (!exp_err) chk("op_cycles", cyc, exp_load + exp_pe + exp_out + 2);
      @(negedge clk);
      chk("pulse_done_low", int'(done), 0);
      chk("pulse_error_low", int'(error), 0);
      chk("busy_after", int'(busy), 0);
      chk("error_code", int'(error_code), exp_code);
      chk_perf("perf_cycles", exp_err ? perf_before : cyc);
      chk("sb_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int k;
      int perf_before;
      tbl[0] = '{32'h0001_0001, 1'b0, 0, 2, 4, 1};
      tbl[1] = '{32'h0002_0003, 1'b0, 0, 5, 7, 2};
      tbl[2] = '{32'h0005_0001, 1'b1, 1, 0, 0, 0};
      tbl[3] = '{32'h0004_0004, 1'b0, 0, 8, 10, 4};
      tbl[4] = '{32'h0000_0002, 1'b1, 1, 0, 0, 0};
      tbl[5] = '{32'h0001_0004, 1'b0, 0, 5, 7, 1};
      tbl[6] = '{32'h0003_0000, 1'b1, 1, 0, 0, 0};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_pe_en", int'(pe_en), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_beat_idx", int'(beat_idx), 0);
      chk("rst_error_code", int'(error_code), 0);
      chk("rst_perf", int'(perf_cycles), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Start with no configuration
      run_op(32'h0001_0001, 1'b0, 1'b1, 2, 0, 0, 0);

      for (int i = 0; i < 7; i++)
         run_op(tbl[i].cfg, 1'b1, tbl[i].err, tbl[i].code,
                tbl[i].nload, tbl[i].npe, tbl[i].nout);

      // Config and start together: config taken, start dropped
      config_valid = 1'b1;
      config_data  = 32'h0001_0002;
      start        = 1'b1;
      @(negedge clk);
      config_valid = 1'b0;
      start        = 1'b0;
      chk("collide_busy", int'(busy), 0);
      chk("collide_error", int'(error), 0);
      @(negedge clk);
      chk("collide_busy2", int'(busy), 0);
      run_op(32'h0001_0002, 1'b0, 1'b0, 0, 3, 5, 1);

      // Output stall in STORE; a config strobe while busy is ignored
      config_valid = 1'b1;
      config_data  = 32'h0002_0002;
      @(negedge clk);
      config_valid = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      start     = 1'b1;
      exp_q.push_back(0);
      exp_q.push_back(1);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin k++; @(negedge clk); end
      chk("stall_reach_store", int'(out_valid), 1);
      config_valid = 1'b1;
      config_data  = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_idx", int'(beat_idx), 0);
         @(negedge clk);
      end
      config_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk("drain_valid", int'(out_valid), 1);
         if (exp_q.size() == 0) chk("drain_underflow", 1, 0);
         else chk("drain_idx", int'(beat_idx), exp_q.pop_front());
         @(negedge clk);
      end
      chk("stall_done", int'(done), 1);
      @(negedge clk);
      exp_q.delete();
      // Config must still be 2x2
      run_op(32'h0002_0002, 1'b0, 1'b0, 0, 4, 6, 2);

      // Abort on the third EXECUTE cycle
      perf_before = int'(perf_cycles);
      config_valid = 1'b1;
      config_data  = 32'h0002_0003;
      @(negedge clk);
      config_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!pe_en && k < 50) begin k++; @(negedge clk); end
      chk("abort_reach_exec", int'(pe_en), 1);
      @(negedge clk);
      chk("abort_exec2", int'(pe_en), 1);
      @(negedge clk);
      chk("abort_exec3", int'(pe_en), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_pe_off", int'(pe_en), 0);
      chk("abort_error", int'(error), 1);
      chk("abort_code", int'(error_code), 3);
      chk("abort_busy", int'(busy), 0);
      chk_perf("abort_perf_kept", perf_before);
      @(negedge clk);
      chk("abort_error_pulse", int'(error), 0);
      chk("abort_code_held", int'(error_code), 3);

      // Reset in mid-operation
      config_valid = 1'b1;
      config_data  = 32'h0004_0004;
      @(negedge clk);
      config_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!pe_en && k < 50) begin k++; @(negedge clk); end
      chk("mid_reach_exec", int'(pe_en), 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_busy", int'(busy), 0);
      chk("mid_pe_en", int'(pe_en), 0);
      chk("mid_code", int'(error_code), 0);
      chk("mid_perf", int'(perf_cycles), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_no_pulse", int'(done | error), 0);
      end
      // Configuration was cleared by reset
      run_op(32'h0001_0001, 1'b0, 1'b1, 2, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
